rptr_empty_fwft: RTL and testbench
==================================

Name: rptr_empty_fwft

Overview:
Read-side pointer, flag and first-word-fall-through (FWFT) output stage for the async FIFO.
- Issues memory reads ahead of demand and absorbs memory read latency RD_LAT in a small output buffer.
- Presents data on a valid/ready interface, so rdata is valid with rvalid and no read-to-data bubble occurs.
- Replaces the plain read-pointer/empty block wherever a streaming consumer attaches to the FIFO.

Parameters:
- ASIZE, 4: log2 of FIFO depth; pointers are ASIZE+1 bits.
- DSIZE, 8: data width.
- RD_LAT, 1: memory read latency in rclk cycles from mem_ren to mem_rdata valid; legal values 1..3.

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- rptr_clr  in  1  synchronous flush of pointer, pipeline and buffer.
- sync_wptr  in  ASIZE+1  Gray write pointer, already synchronised to rclk.
- near_empty_mrgn  in  ASIZE+2  near-empty threshold on rlevel.
- mem_rdata  in  DSIZE  memory read data, RD_LAT cycles after mem_ren.
- mem_ren  out  1  memory read enable.
- raddr  out  ASIZE  memory read address = rbin[ASIZE-1:0].
- rptr  out  ASIZE+1  registered Gray read pointer, to the write-domain synchroniser.
- rdata  out  DSIZE  head-of-buffer data.
- rvalid  out  1  rdata valid.
- rready  in  1  consumer accept; a transfer occurs when rvalid && rready.
- empty  out  1  equals ~rvalid.
- near_empty  out  1  registered, rlevel <= near_empty_mrgn while rvalid.
- under_flow  out  1  consumer requested from an empty FIFO.
- rlevel  out  ASIZE+2  words available to the consumer.

Behaviour:
- Reset:
  - rbin = 0, rptr = 0.
  - Pipeline valid bits = 0, buffer count = 0.
  - rvalid = 0, empty = 1, near_empty = 0, under_flow = 0.
  - rdata = 0, rlevel = 0, mem_ren = 0.
- mem_avail = (rgray != sync_wptr); this is the Gray compare of the current rptr.
- Credit: obuf depth is RD_LAT+1.
  - mem_ren = mem_avail && (inflight + obuf_cnt - pop < RD_LAT+1), where pop = rvalid && rready.
  - mem_ren is combinational and is gated to 0 during rptr_clr.
- On mem_ren:
  - rbin increments by 1 and rptr = bin2gray(rbin+1), both registered.
  - A valid token enters an RD_LAT-deep shift register.
  - When the token exits, mem_rdata is written into obuf.
- Pointer advances by at most 1 per cycle, so rptr changes a single bit per cycle. This is required for CDC.
- Throughput: 1 word/cycle sustained when data is available and rready is held high.
- First-word latency: word present in sync_wptr at cycle N → rvalid at N+RD_LAT+1.
- obuf:
  - FIFO; head drives rdata/rvalid.
  - Simultaneous push and pop is allowed at any count, including full.
  - Push into an empty obuf that is popped in the same cycle is not a bypass. Data appears the next cycle.
- rlevel, registered = (gray2bin(sync_wptr) − rbin) mod 2^(ASIZE+1) + inflight + obuf_cnt. The sum is zero-extended to ASIZE+2 bits.
- near_empty, registered = rvalid_next && (rlevel_next <= near_empty_mrgn). It is never asserted together with empty.
- under_flow, registered = rready && !rvalid. It is a one-cycle pulse (see the optional feature for the sticky variant).
- rptr_clr:
  - Next cycle: rbin = 0, rptr = 0, all tokens are killed, obuf_cnt = 0, rvalid = 0, empty = 1, flags = 0.
  - mem_rdata returning for killed tokens is discarded.
  - rptr_clr takes priority over every other event in the same cycle.
- Wrap-around: rbin wraps modulo 2^(ASIZE+1), and the MSB toggles each lap.
- rdata is held stable while rvalid && !rready.
- Asynchronous reset mid-burst abandons all in-flight reads. No memory side effects.

Optional Feature:
- Macro RPTR_UFLOW_STICKY_EN.
- Defined: under_flow sets on rready && !rvalid and stays 1 until rptr_clr or reset.
- Undefined: under_flow is a one-cycle registered pulse per offending cycle.

Decomposition:
- Shared package (fifo_pkg):
  - bin2gray and gray2bin functions.
  - Pointer width localparam PTR_W = ASIZE+1.
  - Level width localparam LVL_W = ASIZE+2.
  - OBUF_DEPTH = RD_LAT+1.
- Sub-module fwft_obuf: parametrised DSIZE/DEPTH register FIFO.
  - Ports: push, pop, din, dout, count, valid, flush.
  - Instantiated once.

Test Plan:
- Reset, then sync_wptr = 0 → rvalid = 0, empty = 1, mem_ren = 0, rptr = 0, rlevel = 0.
- RD_LAT = 2, sync_wptr = gray(5), rready = 1 from cycle 0 → mem_ren for 5 consecutive cycles, first rvalid at cycle 3, 5 words in order, then empty = 1. rptr ends at gray(5) = 5'b00111.
- RD_LAT = 1, 16 words available, rready held 0 → exactly 2 mem_ren pulses, rlevel = 16, rdata stable. Release rready → 16 words with no gaps.
- near_empty_mrgn = 2 with 4 words available, consumer pops one per cycle → near_empty asserts when rlevel ≤ 2, deasserts when empty rises.
- rptr_clr asserted while 2 reads are in flight → next cycle rvalid = 0, rptr = 0. Late mem_rdata is never presented.
- rready = 1 while empty for 3 cycles → under_flow pulses for 3 cycles. With RPTR_UFLOW_STICKY_EN, it stays 1 until rptr_clr.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default widths of the read side.
package fifo_pkg;

    localparam int unsigned FIFO_ASIZE  = 4;
    localparam int unsigned FIFO_DSIZE  = 8;
    localparam int unsigned FIFO_RD_LAT = 1;
    localparam int unsigned PTR_W       = FIFO_ASIZE + 1;
    localparam int unsigned LVL_W       = FIFO_ASIZE + 2;
    localparam int unsigned OBUF_DEPTH  = FIFO_RD_LAT + 1;

    // Conversions work on a wide word; callers zero-extend and truncate to pointer width.
    localparam int unsigned GW = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fwft_obuf.sv
// Small register FIFO that soaks up memory read latency; head entry is always slot 0.
module fwft_obuf #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [DSIZE-1:0] din,
    output logic [DSIZE-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             valid
);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    wr_idx;

    always_comb begin
        cnt_nxt = count;
        wr_idx  = count - CW'(pop);
        if (flush) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = count + CW'(push) - CW'(pop);
        end
    end

    // Pop shifts toward slot 0; a concurrent push lands just behind the surviving entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= cnt_nxt;
            valid <= (cnt_nxt != '0);
            if (!flush) begin
                if (pop) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        mem[i] <= mem[i+1];
                    end
                end
                if (push) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CW'(i) == wr_idx) begin
                            mem[i] <= din;
                        end
                    end
                end
            end
        end
    end

    assign dout = mem[0];

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read pointer, flags and first-word-fall-through stage of the async FIFO.
// Build option RPTR_UFLOW_STICKY_EN: under_flow latches until rptr_clr or reset.
module rptr_empty_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE  = FIFO_ASIZE,
    parameter int unsigned DSIZE  = FIFO_DSIZE,
    parameter int unsigned RD_LAT = FIFO_RD_LAT
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rptr_clr,
    input  logic [ASIZE:0]   sync_wptr,
    input  logic [ASIZE+1:0] near_empty_mrgn,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             mem_ren,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    output logic             empty,
    output logic             near_empty,
    output logic             under_flow,
    output logic [ASIZE+1:0] rlevel
);

    localparam int unsigned PW    = ASIZE + (PTR_W - FIFO_ASIZE);
    localparam int unsigned LW    = ASIZE + (LVL_W - FIFO_ASIZE);
    localparam int unsigned DEPTH = RD_LAT + (OBUF_DEPTH - FIFO_RD_LAT);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [PW-1:0]     rbin;
    logic [PW-1:0]     rbin_nxt;
    logic [PW-1:0]     wbin;
    logic [PW-1:0]     avail_diff;
    logic [RD_LAT-1:0] tok;
    logic [RD_LAT-1:0] tok_nxt;
    logic [LW-1:0]     inflight;
    logic [LW-1:0]     inflight_nxt;
    logic [LW-1:0]     lvl_nxt;
    logic [CW-1:0]     ob_cnt;
    logic [CW-1:0]     ob_cnt_nxt;
    logic              ob_valid_nxt;
    logic              uflow_nxt;
    logic              pop;
    logic              push;
    logic              mem_avail;

    assign pop       = rvalid && rready;
    assign push      = tok[RD_LAT-1] && !rptr_clr;
    assign mem_avail = (rptr != sync_wptr);
    assign wbin      = PW'(gray2bin(GW'(sync_wptr)));
    assign raddr     = rbin[ASIZE-1:0];
    assign empty     = !rvalid;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LW'(tok[i]);
        end
    end

    // Only issue a read when the buffer is guaranteed a free slot when its data returns.
    assign mem_ren = !rptr_clr && mem_avail
                     && ((inflight + LW'(ob_cnt) - LW'(pop)) < LW'(DEPTH));

    always_comb begin
        rbin_nxt     = rptr_clr ? '0 : rbin + PW'(mem_ren);
        tok_nxt      = rptr_clr ? '0 : RD_LAT'({tok, mem_ren});
        ob_cnt_nxt   = rptr_clr ? '0 : ob_cnt + CW'(push) - CW'(pop);
        ob_valid_nxt = (ob_cnt_nxt != '0);
        avail_diff   = wbin - rbin_nxt;
        inflight_nxt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_nxt = inflight_nxt + LW'(tok_nxt[i]);
        end
        lvl_nxt = rptr_clr ? '0 : LW'(avail_diff) + inflight_nxt + LW'(ob_cnt_nxt);
`ifdef RPTR_UFLOW_STICKY_EN
        uflow_nxt = !rptr_clr && (under_flow || (rready && !rvalid));
`else
        uflow_nxt = !rptr_clr && rready && !rvalid;
`endif
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            tok        <= '0;
            rlevel     <= '0;
            near_empty <= 1'b0;
            under_flow <= 1'b0;
        end else begin
            rbin       <= rbin_nxt;
            rptr       <= PW'(bin2gray(GW'(rbin_nxt)));
            tok        <= tok_nxt;
            rlevel     <= lvl_nxt;
            near_empty <= !rptr_clr && ob_valid_nxt && (lvl_nxt <= near_empty_mrgn);
            under_flow <= uflow_nxt;
        end
    end

    fwft_obuf #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH)
    ) u_obuf (
        .clk   (rclk),
        .rst_n (rrst_n),
        .flush (rptr_clr),
        .push  (push),
        .pop   (pop),
        .din   (mem_rdata),
        .dout  (rdata),
        .count (ob_cnt),
        .valid (rvalid)
    );

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Directed bench for rptr_empty_fwft: one RD_LAT=1 and one RD_LAT=2 instance on shared inputs.
module tb_rptr_empty_fwft;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rptr_clr;
    logic       rready;
    logic [4:0] sync_wptr;
    logic [5:0] mrgn;

    logic [7:0] mem_rdata_a, rdata_a, mem_rdata_b, rdata_b;
    logic       ren_a, rvalid_a, empty_a, near_a, uf_a;
    logic       ren_b, rvalid_b, empty_b, near_b, uf_b;
    logic [3:0] raddr_a, raddr_b;
    logic [4:0] rptr_a, rptr_b;
    logic [5:0] rlevel_a, rlevel_b;

    logic [3:0] a_d1, b_d1, b_d2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 rclk = ~rclk;

    function automatic logic [7:0] memv(input logic [3:0] a);
        return 8'h10 + {4'h0, a};
    endfunction

    // Memory model: data for the address issued with mem_ren appears RD_LAT cycles later.
    always @(posedge rclk) begin
        a_d1 <= raddr_a;
        b_d1 <= raddr_b;
        b_d2 <= b_d1;
    end
    assign mem_rdata_a = memv(a_d1);
    assign mem_rdata_b = memv(b_d2);

    rptr_empty_fwft #(.ASIZE(4), .DSIZE(8), .RD_LAT(1)) u_a (
        .rclk(rclk), .rrst_n(rrst_n), .rptr_clr(rptr_clr), .sync_wptr(sync_wptr),
        .near_empty_mrgn(mrgn), .mem_rdata(mem_rdata_a), .mem_ren(ren_a), .raddr(raddr_a),
        .rptr(rptr_a), .rdata(rdata_a), .rvalid(rvalid_a), .rready(rready), .empty(empty_a),
        .near_empty(near_a), .under_flow(uf_a), .rlevel(rlevel_a)
    );

    rptr_empty_fwft #(.ASIZE(4), .DSIZE(8), .RD_LAT(2)) u_b (
        .rclk(rclk), .rrst_n(rrst_n), .rptr_clr(rptr_clr), .sync_wptr(sync_wptr),
        .near_empty_mrgn(mrgn), .mem_rdata(mem_rdata_b), .mem_ren(ren_b), .raddr(raddr_b),
        .rptr(rptr_b), .rdata(rdata_b), .rvalid(rvalid_b), .rready(rready), .empty(empty_b),
        .near_empty(near_b), .under_flow(uf_b), .rlevel(rlevel_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_clear();
        rptr_clr  = 1'b1;
        sync_wptr = 5'b0;
        rready    = 1'b0;
        mrgn      = 6'd0;
        tick();
        rptr_clr = 1'b0;
        tick();
    endtask

    initial begin
        int         ren_cnt;
        logic [6:0] ev_valid;
        logic [6:0] ev_near;
        logic [6:0] ev_uf;
        int         lv [7];

        rrst_n    = 1'b0;
        rptr_clr  = 1'b0;
        rready    = 1'b0;
        sync_wptr = 5'b0;
        mrgn      = 6'd0;
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;

        // Reset state
        @(negedge rclk);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_empty_a",  32'(empty_a),  32'd1);
        chk("rst_ren_a",    32'(ren_a),    32'd0);
        chk("rst_rptr_a",   32'(rptr_a),   32'd0);
        chk("rst_rlevel_a", 32'(rlevel_a), 32'd0);
        chk("rst_near_a",   32'(near_a),   32'd0);
        chk("rst_uf_a",     32'(uf_a),     32'd0);
        chk("rst_rdata_a",  32'(rdata_a),  32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("rst_ren_b",    32'(ren_b),    32'd0);
        tick();

        // RD_LAT=2, five words streamed with rready high
        sync_wptr = 5'b00111;
        rready    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            chk($sformatf("t2_ren_c%0d", c), 32'(ren_b), 32'(c < 5));
            chk($sformatf("t2_rvalid_c%0d", c), 32'(rvalid_b), 32'(c >= 3 && c < 8));
            if (c >= 3 && c < 8) begin
                chk($sformatf("t2_rdata_c%0d", c), 32'(rdata_b), 32'h10 + 32'(c - 3));
            end
            tick();
        end
        @(negedge rclk);
        chk("t2_rptr_end", 32'(rptr_b), 32'b00111);
        chk("t2_empty_end", 32'(empty_b), 32'd1);
        tick();
        do_clear();
        @(negedge rclk);
        chk("clr_rptr_a", 32'(rptr_a), 32'd0);
        chk("clr_rptr_b", 32'(rptr_b), 32'd0);
        tick();

        // RD_LAT=1, full FIFO with consumer stalled, then drained with wrap of the pointer MSB
        sync_wptr = 5'b11000;
        rready    = 1'b0;
        ren_cnt   = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            ren_cnt += int'(ren_a);
            if (c >= 2) begin
                chk($sformatf("t3_hold_rvalid_c%0d", c), 32'(rvalid_a), 32'd1);
                chk($sformatf("t3_hold_rdata_c%0d", c), 32'(rdata_a), 32'h10);
            end
            tick();
        end
        @(negedge rclk);
        chk("t3_ren_pulses", 32'(ren_cnt), 32'd2);
        chk("t3_rlevel_full", 32'(rlevel_a), 32'd16);
        tick();
        rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            chk($sformatf("t3_stream_rvalid_%0d", i), 32'(rvalid_a), 32'd1);
            chk($sformatf("t3_stream_rdata_%0d", i), 32'(rdata_a), 32'h10 + 32'(i));
            tick();
        end
        @(negedge rclk);
        chk("t3_rvalid_end", 32'(rvalid_a), 32'd0);
        chk("t3_empty_end",  32'(empty_a),  32'd1);
        chk("t3_rptr_wrap",  32'(rptr_a),   32'b11000);
        chk("t3_rlevel_end", 32'(rlevel_a), 32'd0);
        tick();
        do_clear();

        // near_empty with margin 2 over four words, one pop per cycle
        ev_valid = 7'b0111100;
        ev_near  = 7'b0110000;
        lv       = '{0, 4, 4, 3, 2, 1, 0};
        mrgn      = 6'd2;
        sync_wptr = 5'b00110;
        for (int c = 0; c < 7; c++) begin
            rready = (c >= 2 && c <= 5);
            @(negedge rclk);
            chk($sformatf("t4_rvalid_c%0d", c), 32'(rvalid_a), 32'(ev_valid[c]));
            chk($sformatf("t4_near_c%0d", c),   32'(near_a),   32'(ev_near[c]));
            chk($sformatf("t4_rlevel_c%0d", c), 32'(rlevel_a), 32'(lv[c]));
            chk($sformatf("t4_uf_c%0d", c),     32'(uf_a),     32'd0);
            tick();
        end
        do_clear();

        // RD_LAT=2, flush with two reads in flight
        sync_wptr = 5'b00111;
        rready    = 1'b0;
        @(negedge rclk);
        chk("t5_ren_c0", 32'(ren_b), 32'd1);
        tick();
        @(negedge rclk);
        chk("t5_ren_c1", 32'(ren_b), 32'd1);
        tick();
        rptr_clr  = 1'b1;
        sync_wptr = 5'b0;
        @(negedge rclk);
        chk("t5_ren_gated", 32'(ren_b), 32'd0);
        chk("t5_rptr_before", 32'(rptr_b), 32'b00011);
        tick();
        rptr_clr = 1'b0;
        @(negedge rclk);
        chk("t5_rptr_after",   32'(rptr_b),   32'd0);
        chk("t5_empty_after",  32'(empty_b),  32'd1);
        chk("t5_rlevel_after", 32'(rlevel_b), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            chk($sformatf("t5_no_late_data_%0d", c), 32'(rvalid_b), 32'd0);
            tick();
        end

        // Underflow: rready while empty for three cycles, flush at cycle 5
`ifdef RPTR_UFLOW_STICKY_EN
        ev_uf = 7'b0111110;
`else
        ev_uf = 7'b0001110;
`endif
        for (int c = 0; c < 7; c++) begin
            rready   = (c < 3);
            rptr_clr = (c == 5);
            @(negedge rclk);
            chk($sformatf("t6_uf_a_c%0d", c), 32'(uf_a), 32'(ev_uf[c]));
            chk($sformatf("t6_uf_b_c%0d", c), 32'(uf_b), 32'(ev_uf[c]));
            tick();
        end
        rptr_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
